// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port fetch/data arbiter for the shared memory bus
// Optional fetch starvation limiter enabled by defining ARB_STARVE_LIMIT_EN.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_rd_req,
    output logic        i_rw_wait,
    output logic [31:0] i_rd_data,
    input  logic [31:0] d_addr,
    input  logic        d_rd_req,
    input  logic        d_wr_req,
    input  logic [31:0] d_wr_data,
    input  logic [2:0]  d_data_size,
    input  logic        d_lock,
    output logic        d_rw_wait,
    output logic [31:0] d_rd_data,
    output logic [31:0] busaddr,
    output logic        rd_req,
    output logic        wr_req,
    output logic [31:0] wr_data,
    output logic [2:0]  data_size,
    input  logic        rw_wait,
    input  logic [31:0] rd_data,
    output logic        grant_i,
    output logic        grant_d
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;

    logic [1:0] owner_q, owner_d;
    logic [1:0] cur;
    logic       d_req;
    logic       bus_req;
    logic       xfer_done;
    logic       starve_hit;

    assign d_req     = d_rd_req | d_wr_req;
    assign bus_req   = (cur == ST_FETCH) | ((cur == ST_DATA) & d_req);
    assign xfer_done = bus_req & ~rw_wait;

`ifdef ARB_STARVE_LIMIT_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    // Override never breaks an ongoing transfer or lock: it only feeds arbitration.
    assign starve_hit = i_rd_req & (starve_cnt_q == LIMIT);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_rd_req || (xfer_done && (cur == ST_FETCH))) begin
            starve_cnt_d = 4'd0;
        end else if (xfer_done && (cur == ST_DATA) && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^4'(STARVE_LIMIT);
    assign starve_hit          = 1'b0;
`endif

    // Held ownership first (in-flight transfer or locked data), then arbitration.
    always_comb begin
        cur = ST_IDLE;
        if ((owner_q == ST_FETCH) && i_rd_req) begin
            cur = ST_FETCH;
        end else if ((owner_q == ST_DATA) && (d_req || d_lock)) begin
            cur = ST_DATA;
        end else if (starve_hit) begin
            cur = ST_FETCH;
        end else if (d_req) begin
            cur = ST_DATA;
        end else if (i_rd_req) begin
            cur = ST_FETCH;
        end
    end

    always_comb begin
        owner_d = ST_IDLE;
        if ((cur == ST_DATA) && !d_req) begin
            owner_d = ST_DATA;
        end else if (bus_req && rw_wait) begin
            owner_d = cur;
        end else if (xfer_done && (cur == ST_DATA) && d_lock) begin
            owner_d = ST_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= ST_IDLE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        busaddr   = 'x;
        wr_data   = 'x;
        data_size = 'x;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        case (cur)
            ST_FETCH: begin
                busaddr   = i_addr;
                rd_req    = 1'b1;
                data_size = 3'b100;
            end
            ST_DATA: begin
                busaddr   = d_addr;
                rd_req    = d_rd_req;
                wr_req    = d_wr_req;
                wr_data   = d_wr_data;
                data_size = d_data_size;
            end
            default: ;
        endcase
        if (rst) begin
            rd_req = 1'b0;
            wr_req = 1'b0;
        end
    end

    assign grant_i   = ~rst & (cur == ST_FETCH);
    assign grant_d   = ~rst & (cur == ST_DATA);
    assign i_rw_wait = rst | (i_rd_req & ((cur == ST_FETCH) ? rw_wait : 1'b1));
    assign d_rw_wait = rst | (d_req & ((cur == ST_DATA) ? rw_wait : 1'b1));
    assign i_rd_data = rd_data;
    assign d_rd_data = rd_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and randomized check of mem_bus_arbiter against a reference model
module tb_mem_bus_arbiter;

    localparam int LIMIT = 4;
    localparam int W_NONE  = 0;
    localparam int W_FETCH = 1;
    localparam int W_DATA  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic        i_rd_req;
    logic        i_rw_wait;
    logic [31:0] i_rd_data;
    logic [31:0] d_addr;
    logic        d_rd_req;
    logic        d_wr_req;
    logic [31:0] d_wr_data;
    logic [2:0]  d_data_size;
    logic        d_lock;
    logic        d_rw_wait;
    logic [31:0] d_rd_data;
    logic [31:0] busaddr;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] wr_data;
    logic [2:0]  data_size;
    logic        rw_wait;
    logic [31:0] rd_data;
    logic        grant_i;
    logic        grant_d;

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_rd_req(i_rd_req), .i_rw_wait(i_rw_wait), .i_rd_data(i_rd_data),
        .d_addr(d_addr), .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_wr_data(d_wr_data),
        .d_data_size(d_data_size), .d_lock(d_lock), .d_rw_wait(d_rw_wait), .d_rd_data(d_rd_data),
        .busaddr(busaddr), .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data),
        .data_size(data_size), .rw_wait(rw_wait), .rd_data(rd_data),
        .grant_i(grant_i), .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // requester-side stimulus state
    bit          rst_v;
    bit          f_pend;
    logic [31:0] f_addr;
    bit          d_pend;
    bit          d_wr;
    logic [31:0] d_a;
    logic [31:0] d_wd;
    logic [2:0]  d_sz;
    bit          lock;
    bit          rw_w;
    logic [31:0] rd_v;

    // reference model: who holds the bus across cycles, and consecutive data wins against a waiting fetch
    int m_holder = W_NONE;
    int m_starve = 0;

    // observed DUT values from the most recent cycle
    logic        obs_gi, obs_gd, obs_iw, obs_dw, obs_rd, obs_wr;
    logic [31:0] obs_addr;

    function automatic int pick_winner();
        if (m_holder == W_FETCH && f_pend) return W_FETCH;
        if (m_holder == W_DATA && (d_pend || lock)) return W_DATA;
`ifdef ARB_STARVE_LIMIT_EN
        if (f_pend && m_starve == LIMIT) return W_FETCH;
`endif
        if (d_pend) return W_DATA;
        if (f_pend) return W_FETCH;
        return W_NONE;
    endfunction

    task automatic apply();
        rd_v        = $urandom;
        rst         = rst_v;
        i_rd_req    = f_pend;
        i_addr      = f_addr;
        d_rd_req    = d_pend && !d_wr;
        d_wr_req    = d_pend && d_wr;
        d_addr      = d_a;
        d_wr_data   = d_wd;
        d_data_size = d_sz;
        d_lock      = lock;
        rw_wait     = rw_w;
        rd_data     = rd_v;
    endtask

    task automatic cycle();
        int         win;
        bit         on_bus, f_done, d_done;
        logic [5:0] exp_ctl;
        apply();
        #3;
        obs_gi = grant_i; obs_gd = grant_d; obs_iw = i_rw_wait; obs_dw = d_rw_wait;
        obs_rd = rd_req;  obs_wr = wr_req;  obs_addr = busaddr;
        check_eq("rdata_i", i_rd_data, rd_v);
        check_eq("rdata_d", d_rd_data, rd_v);
        if (rst_v) begin
            check_eq("ctl_rst", {26'd0, grant_i, grant_d, rd_req, wr_req, i_rw_wait, d_rw_wait},
                     32'b000011);
            m_holder = W_NONE;
            m_starve = 0;
        end else begin
            win    = pick_winner();
            on_bus = (win == W_FETCH) || (win == W_DATA && d_pend);
            exp_ctl[5] = (win == W_FETCH);
            exp_ctl[4] = (win == W_DATA);
            exp_ctl[3] = (win == W_FETCH) || (win == W_DATA && d_pend && !d_wr);
            exp_ctl[2] = (win == W_DATA && d_pend && d_wr);
            exp_ctl[1] = f_pend && ((win == W_FETCH) ? rw_w : 1'b1);
            exp_ctl[0] = d_pend && ((win == W_DATA) ? rw_w : 1'b1);
            check_eq("ctl", {26'd0, grant_i, grant_d, rd_req, wr_req, i_rw_wait, d_rw_wait},
                     {26'd0, exp_ctl});
            if (win == W_FETCH) begin
                check_eq("f_addr", busaddr, f_addr);
                check_eq("f_size", {29'd0, data_size}, 32'd4);
            end else if (win == W_DATA && d_pend) begin
                check_eq("d_addr", busaddr, d_a);
                check_eq("d_size", {29'd0, data_size}, {29'd0, d_sz});
                if (d_wr) check_eq("d_wdata", wr_data, d_wd);
            end
            f_done = (win == W_FETCH) && !rw_w;
            d_done = (win == W_DATA) && d_pend && !rw_w;
            if (win == W_NONE)      m_holder = W_NONE;
            else if (!on_bus)       m_holder = W_DATA;
            else if (rw_w)          m_holder = win;
            else                    m_holder = (win == W_DATA && lock) ? W_DATA : W_NONE;
            if (!f_pend || f_done)              m_starve = 0;
            else if (d_done && m_starve < LIMIT) m_starve++;
            if (f_done) f_pend = 0;
            if (d_done) d_pend = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        f_pend = 0; d_pend = 0; lock = 0; rw_w = 0; rst_v = 0;
        cycle();
    endtask

    initial begin
        rst_v = 1; f_pend = 0; d_pend = 0; d_wr = 0; lock = 0; rw_w = 0;
        f_addr = 0; d_a = 0; d_wd = 0; d_sz = 3'b100;
        cycle();
        f_pend = 1; f_addr = 32'h500;
        cycle();
        check_eq("rst_gi", {31'd0, obs_gi}, 32'd0);
        check_eq("rst_iw", {31'd0, obs_iw}, 32'd1);
        settle();

        // fetch alone, zero-latency grant
        f_pend = 1; f_addr = 32'h100;
        cycle();
        check_eq("t1_gi", {31'd0, obs_gi}, 32'd1);
        check_eq("t1_addr", obs_addr, 32'h100);
        check_eq("t1_iw", {31'd0, obs_iw}, 32'd0);
        settle();

        // simultaneous requests: data first, then fetch
        f_pend = 1; f_addr = 32'h200; d_pend = 1; d_wr = 0; d_a = 32'h2000; d_sz = 3'b100;
        cycle();
        check_eq("t2_gd", {31'd0, obs_gd}, 32'd1);
        check_eq("t2_iw", {31'd0, obs_iw}, 32'd1);
        cycle();
        check_eq("t2_gi", {31'd0, obs_gi}, 32'd1);
        check_eq("t2_addr", obs_addr, 32'h200);
        settle();

        // stalled fetch keeps the bus while data waits
        f_pend = 1; f_addr = 32'h300; rw_w = 1;
        cycle();
        check_eq("t3_addr0", obs_addr, 32'h300);
        d_pend = 1; d_wr = 0; d_a = 32'h3000;
        for (int k = 1; k < 3; k++) begin
            cycle();
            check_eq("t3_addr", obs_addr, 32'h300);
        end
        rw_w = 0;
        cycle();
        check_eq("t3_done", {31'd0, obs_gi}, 32'd1);
        cycle();
        check_eq("t3_gd", {31'd0, obs_gd}, 32'd1);
        check_eq("t3_daddr", obs_addr, 32'h3000);
        settle();

        // SWP: locked read, idle cycle, unlocked write; fetch waits throughout
        f_pend = 1; f_addr = 32'h400; d_pend = 1; d_wr = 0; d_a = 32'h40; lock = 1;
        cycle();
        check_eq("t4_rd", {31'd0, obs_gd}, 32'd1);
        cycle();
        check_eq("t4_idle", {30'd0, obs_gi, obs_gd}, 32'b01);
        d_pend = 1; d_wr = 1; d_wd = 32'hDEADBEEF; lock = 0;
        cycle();
        check_eq("t4_wr", {30'd0, obs_gi, obs_wr}, 32'b01);
        cycle();
        check_eq("t4_fetch", {31'd0, obs_gi}, 32'd1);
        settle();

        // continuous unlocked data reads against a waiting fetch
        f_pend = 1; f_addr = 32'h600;
        for (int k = 0; k < LIMIT; k++) begin
            d_pend = 1; d_wr = 0; d_a = 32'h6000 + k * 4;
            cycle();
            check_eq("t5_data", {31'd0, obs_gd}, 32'd1);
        end
        d_pend = 1; d_a = 32'h7000;
        cycle();
`ifdef ARB_STARVE_LIMIT_EN
        check_eq("t5_starve", {31'd0, obs_gi}, 32'd1);
`else
        check_eq("t5_strict", {31'd0, obs_gd}, 32'd1);
`endif
        cycle();
        settle();

        // reset in the middle of a stalled data transfer
        d_pend = 1; d_wr = 1; d_a = 32'h800; d_wd = 32'h1234; rw_w = 1;
        cycle();
        check_eq("t6_gd", {31'd0, obs_gd}, 32'd1);
        rst_v = 1;
        cycle();
        check_eq("t6_req", {30'd0, obs_rd, obs_wr}, 32'd0);
        rst_v = 0; d_pend = 0; rw_w = 0; f_pend = 1; f_addr = 32'h700;
        cycle();
        check_eq("t6_gi", {31'd0, obs_gi}, 32'd1);
        check_eq("t6_addr", obs_addr, 32'h700);
        settle();

        // randomized traffic obeying the requester hold rules
        for (int n = 0; n < 4000; n++) begin
            rst_v = ($urandom_range(0, 199) == 0);
            if (!f_pend && $urandom_range(0, 2) == 0) begin
                f_pend = 1;
                f_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                d_wr   = $urandom_range(0, 1);
                d_a    = $urandom;
                d_wd   = $urandom;
                case ($urandom_range(0, 2))
                    0:       d_sz = 3'b001;
                    1:       d_sz = 3'b010;
                    default: d_sz = 3'b100;
                endcase
            end
            lock = ($urandom_range(0, 3) == 0);
            rw_w = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter that shares the single memory bus between the instruction-fetch requester and the Memory pipeline stage. It sits between both requesters and the bus (or cache) port, and uses the same busaddr/rd_req/wr_req/rw_wait/data_size handshake on every side. Data accesses take priority by default. A lock input keeps SWP read-write pairs and LDM/STM bursts atomic. An optional starvation limiter guarantees fetch progress.

## Interface
Parameters:
- STARVE_LIMIT, 4: number of consecutive completed data transfers a waiting fetch tolerates. Used only with ARB_STARVE_LIMIT_EN. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- i_addr  in  32  fetch address
- i_rd_req  in  1  fetch read request; held until i_rw_wait low
- i_rw_wait  out  1  fetch stall
- i_rd_data  out  32  fetch read data (bus rd_data passthrough)
- d_addr  in  32  data address
- d_rd_req  in  1  data read request
- d_wr_req  in  1  data write request; never asserted together with d_rd_req
- d_wr_data  in  32  data write value
- d_data_size  in  3  3'b001 byte, 3'b010 half, 3'b100 word
- d_lock  in  1  keep data ownership after the current transfer (SWP, LDM/STM)
- d_rw_wait  out  1  data stall
- d_rd_data  out  32  data read data (bus rd_data passthrough)
- busaddr  out  32  bus address
- rd_req  out  1  bus read request
- wr_req  out  1  bus write request
- wr_data  out  32  bus write data
- data_size  out  3  bus access size
- rw_wait  in  1  bus stall; a transfer completes in a cycle where the request is high and rw_wait is low
- rd_data  in  32  bus read data
- grant_i  out  1  fetch owns the bus this cycle
- grant_d  out  1  data owns the bus this cycle

## Operation
- The registered state `owner` is one of IDLE, FETCH or DATA. It resets to IDLE.
- The effective owner `cur` is computed combinationally each cycle:
  - If `owner` is FETCH or DATA and that requester's request is high, `cur` = `owner`.
  - If `owner` is DATA, d_lock is high and the data request is low, `cur` = DATA. The bus stays idle and the fetch is held off.
  - Otherwise `cur` is decided by arbitration. Priority: DATA if a data request is high, else FETCH if i_rd_req is high, else IDLE.
- Starvation override (ARB_STARVE_LIMIT_EN only): if `starve_cnt` == STARVE_LIMIT and i_rd_req is high, arbitration picks FETCH over DATA. The override does not break an existing lock.
- Bus muxing:
  - cur = FETCH: busaddr = i_addr, rd_req = 1, wr_req = 0, data_size = 3'b100, wr_data = 32'hxxxxxxxx.
  - cur = DATA: busaddr, rd_req, wr_req, wr_data and data_size come from the d_ ports.
  - cur = IDLE: rd_req = wr_req = 0, all other bus outputs are x.
- Waits:
  - The owner's wait is rw_wait.
  - A requester that is requesting but not the owner sees wait = 1.
  - A requester that is not requesting sees wait = 0.
- Next `owner`:
  - On a completing transfer: DATA if cur = DATA and d_lock = 1, else IDLE.
  - On a stalled transfer (rw_wait high): `owner` = `cur`.
  - When cur = IDLE: `owner` = IDLE.
- grant_i = (cur == FETCH) and grant_d = (cur == DATA). At most one is high in any cycle.
- d_lock is only sampled when a data transfer completes, or in DATA ownership while the data request is idle. Dropping d_lock while the data request is idle returns `owner` to IDLE.

## Timing
- Grant is zero-latency. A request into IDLE reaches the bus in the same cycle. A back-to-back request after completion is re-arbitrated in the next cycle with no dead cycle.
- Bus signals, waits and grants are combinational from the inputs and `owner`. There is no combinational path from rw_wait to any bus output.
- Ownership never changes while rw_wait is high with a request outstanding. Address, data and size stay stable mid-transfer provided the requester holds its inputs.
- Simultaneous first requests from both sides: DATA wins. Fetch sees i_rw_wait = 1 until data releases.
- Reset:
  - While rst is high: rd_req = wr_req = 0, i_rw_wait = d_rw_wait = 1, grant_i = grant_d = 0.
  - On the next edge: `owner` = IDLE, starve_cnt = 0.
  - Reset mid-transfer abandons the transfer with no completion reported.

## Configuration
- ARB_STARVE_LIMIT_EN defined: a 4-bit `starve_cnt` is kept.
  - It increments on each completed DATA transfer while i_rd_req is high.
  - It saturates at STARVE_LIMIT.
  - It clears on a completed FETCH transfer, or whenever i_rd_req is low.
  - When it equals STARVE_LIMIT, FETCH wins the next arbitration.
- ARB_STARVE_LIMIT_EN undefined: strict data priority with no counter. Fetch can starve indefinitely under continuous data traffic.

## Test plan
- Fetch only, i_addr = 32'h100, rw_wait low -> same cycle busaddr = 32'h100, rd_req = 1, data_size = 3'b100, grant_i = 1, i_rw_wait = 0.
- Both requesters assert in the same cycle, d_addr = 32'h2000 (read), rw_wait low -> data served first with i_rw_wait = 1, then the fetch is served next cycle.
- Fetch owns the bus with rw_wait high for 3 cycles while a data request arrives -> busaddr stays at the fetch address for all 3 cycles, and data is granted in the cycle after completion.
- SWP: data read at 32'h40 with d_lock = 1, one idle cycle, then a write 32'hDEADBEEF with d_lock = 0, fetch pending throughout -> fetch is never granted between the read and the write, and is granted right after the write.
- ARB_STARVE_LIMIT_EN, STARVE_LIMIT = 4, continuous unlocked data reads plus a waiting fetch -> after the 4th data completion grant_i = 1 and starve_cnt returns to 0 after the fetch completes.
- rst asserted mid-data-transfer -> rd_req = wr_req = 0 that cycle, then `owner` = IDLE, and a new fetch is granted immediately after rst deasserts.
